mem_stage_access_ctrl: RTL

- Memory-stage initiator that drives the 16-bit data/stack memory: write_enable, read_enable, address, write_data out; read_data in.
- Executes LOAD/STORE (16-bit) and PUSH/POP (16-bit), plus PUSH32/POP32 for the 32-bit PC on CALL/RET/interrupt, which take two memory beats.
- Owns the stack pointer (SP). Raises busy so the pipeline stalls during multi-cycle operations.

---
 rtl/mem_stage_access_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_access_ctrl.sv
// Memory-stage initiator for the 16-bit data/stack memory: LOAD/STORE, PUSH/POP and two-beat PUSH32/POP32.
// Optional macro STACK_LIMIT_CHECK_EN adds stack overflow/underflow detection; when undefined SP wraps freely.
module mem_stage_access_ctrl #(
  parameter int data_width      = 16,
  parameter int address_width   = 32,
  parameter int num_of_register = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic [2:0]                op,
  input  logic [address_width-1:0]  ea,
  input  logic [2*data_width-1:0]   wdata,
  output logic                      busy,
  output logic                      done,
  output logic [2*data_width-1:0]   rdata,
  output logic [address_width-1:0]  sp,
  output logic                      stack_err,
  output logic                      mem_we,
  output logic                      mem_re,
  output logic [address_width-1:0]  mem_addr,
  output logic [data_width-1:0]     mem_wdata,
  input  logic [data_width-1:0]     mem_rdata
);

  localparam logic [address_width-1:0] SP_TOP = address_width'((1 << num_of_register) - 1);

  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_PUSH   = 3'd3;
  localparam logic [2:0] OP_POP    = 3'd4;
  localparam logic [2:0] OP_PUSH32 = 3'd5;
  localparam logic [2:0] OP_POP32  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [2:0]                 r_op;
  logic [address_width-1:0]   r_ea;
  logic [2*data_width-1:0]    r_wdata;
  logic [address_width-1:0]   r_sp;
  logic [2*data_width-1:0]    r_rdata;
  logic [data_width-1:0]      r_lo;
  logic                       r_done;
  logic                       r_stack_err;

  logic                       w_op_valid;
  logic                       w_is32;
  logic                       w_err;
  logic                       w_final;
  logic                       w_we;
  logic                       w_re;
  logic [address_width-1:0]   w_addr;
  logic [data_width-1:0]      w_wdata;

  assign w_op_valid = (op != 3'd0) && (op != 3'd7);
  assign w_is32     = (r_op == OP_PUSH32) || (r_op == OP_POP32);

`ifdef STACK_LIMIT_CHECK_EN
  logic [address_width:0] w_sp_ext;
  logic                   w_ovf;
  logic                   w_unf;

  assign w_sp_ext = {1'b0, r_sp};
  assign w_ovf = ((r_op == OP_PUSH)   && (r_sp < address_width'(1))) ||
                 ((r_op == OP_PUSH32) && (r_sp < address_width'(2)));
  // Extended width so sp+n cannot wrap past SP_TOP unnoticed
  assign w_unf = ((r_op == OP_POP)   && ((w_sp_ext + (address_width+1)'(1)) > {1'b0, SP_TOP})) ||
                 ((r_op == OP_POP32) && ((w_sp_ext + (address_width+1)'(2)) > {1'b0, SP_TOP}));
  assign w_err = (r_state == S_BEAT0) && (w_ovf || w_unf);
`else
  assign w_err = 1'b0;
`endif

  assign w_final = ((r_state == S_BEAT0) && (!w_is32 || w_err)) || (r_state == S_BEAT1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req && w_op_valid) w_state_nxt = S_BEAT0;
      S_BEAT0: w_state_nxt = (w_is32 && !w_err) ? S_BEAT1 : S_IDLE;
      S_BEAT1: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes decode purely from registered state, so an async reset drops them at once
  always_comb begin
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    if (r_state == S_BEAT0 && !w_err) begin
      case (r_op)
        OP_LOAD:   begin w_re = 1'b1; w_addr = r_ea; end
        OP_STORE:  begin w_we = 1'b1; w_addr = r_ea; w_wdata = r_wdata[data_width-1:0]; end
        OP_PUSH:   begin w_we = 1'b1; w_addr = r_sp; w_wdata = r_wdata[data_width-1:0]; end
        OP_POP:    begin w_re = 1'b1; w_addr = r_sp + address_width'(1); end
        OP_PUSH32: begin w_we = 1'b1; w_addr = r_sp; w_wdata = r_wdata[2*data_width-1:data_width]; end
        OP_POP32:  begin w_re = 1'b1; w_addr = r_sp + address_width'(1); end
        default:   ;
      endcase
    end else if (r_state == S_BEAT1) begin
      case (r_op)
        OP_PUSH32: begin w_we = 1'b1; w_addr = r_sp - address_width'(1); w_wdata = r_wdata[data_width-1:0]; end
        OP_POP32:  begin w_re = 1'b1; w_addr = r_sp + address_width'(2); end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 3'd0;
      r_sp        <= SP_TOP;
      r_done      <= 1'b0;
      r_stack_err <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_done      <= w_final;
      r_stack_err <= w_final && w_err;
      if (r_state == S_IDLE && req && w_op_valid) r_op <= op;
      if (w_final && !w_err) begin
        case (r_op)
          OP_PUSH:   r_sp <= r_sp - address_width'(1);
          OP_POP:    r_sp <= r_sp + address_width'(1);
          OP_PUSH32: r_sp <= r_sp - address_width'(2);
          OP_POP32:  r_sp <= r_sp + address_width'(2);
          default:   ;
        endcase
      end
      if (r_state == S_BEAT0 && !w_err && (r_op == OP_LOAD || r_op == OP_POP))
        r_rdata <= {{data_width{1'b0}}, mem_rdata};
      else if (r_state == S_BEAT1 && r_op == OP_POP32)
        r_rdata <= {mem_rdata, r_lo};
    end
  end

  // Operand latches carry data only and need no reset
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req && w_op_valid) begin
      r_ea    <= ea;
      r_wdata <= wdata;
    end
    if (r_state == S_BEAT0 && r_op == OP_POP32) r_lo <= mem_rdata;
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign stack_err = r_stack_err;
  assign rdata     = r_rdata;
  assign sp        = r_sp;
  assign mem_we    = w_we;
  assign mem_re    = w_re;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;

endmodule
